// File: rtl/fifo_rd_ctrl_prog.sv
// Read-domain controller for the async FIFO.
// Owns the read pointer; flags empty, almost-empty, level and underflow.
module fifo_rd_ctrl_prog #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int PTR_W  = ADDR_W + 1,
    parameter int AE_RST = 2
) (
    input  logic              RCLK,
    input  logic              RRSTn,
    input  logic              RINC,
    input  logic [PTR_W-1:0]  RQ2_WPTR,
    input  logic              RAE_WE,
    input  logic [PTR_W-1:0]  RAE_THRESH,
    input  logic              RUF_CLR,
    output logic [PTR_W-1:0]  RPTR,
    output logic [ADDR_W-1:0] RADDR,
    output logic              REMPTY,
    output logic              RALMOST_EMPTY,
    output logic [PTR_W-1:0]  RLEVEL,
    output logic              RUNDERFLOW
);

    localparam logic [PTR_W-1:0] THR_RST = PTR_W'(AE_RST);

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b = '0;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] thresh;

    logic             pop;
    logic             uf_set;
    logic [PTR_W-1:0] rbin_nxt;
    logic [PTR_W-1:0] rgray_nxt;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] level_nxt;
    logic             empty_nxt;
    logic             ae_nxt;
    logic             uf_nxt;

    // Next pointer, level and flag values from this cycle's request.
    always_comb begin
        pop       = RINC & ~REMPTY;
        uf_set    = RINC & REMPTY;
        rbin_nxt  = rbin + PTR_W'(pop);
        rgray_nxt = rbin_nxt ^ (rbin_nxt >> 1);
        wbin      = gray2bin(RQ2_WPTR);
        level_nxt = wbin - rbin_nxt;
        empty_nxt = (rgray_nxt == RQ2_WPTR);
        ae_nxt    = (level_nxt <= thresh);
        uf_nxt    = RUNDERFLOW;
        if (RUF_CLR) begin
            uf_nxt = 1'b0;
        end
        if (uf_set) begin
            uf_nxt = 1'b1;
        end
    end

    // Pointer registers: binary count plus its Gray and address images.
    always_ff @(posedge RCLK) begin
        if (!RRSTn) begin
            rbin  <= '0;
            RPTR  <= '0;
            RADDR <= '0;
        end else begin
            rbin  <= rbin_nxt;
            RPTR  <= rgray_nxt;
            RADDR <= rbin_nxt[ADDR_W-1:0];
        end
    end

    // Status flags and fill level, all registered off next-state values.
    always_ff @(posedge RCLK) begin
        if (!RRSTn) begin
            REMPTY        <= 1'b1;
            RALMOST_EMPTY <= 1'b1;
            RLEVEL        <= '0;
            RUNDERFLOW    <= 1'b0;
        end else begin
            REMPTY        <= empty_nxt;
            RALMOST_EMPTY <= ae_nxt;
            RLEVEL        <= level_nxt;
            RUNDERFLOW    <= uf_nxt;
        end
    end

    // Almost-empty threshold; a new value is used from the cycle after loading.
    always_ff @(posedge RCLK) begin
        if (!RRSTn) begin
            thresh <= THR_RST;
        end else if (RAE_WE) begin
            thresh <= RAE_THRESH;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl_prog.sv
// Testbench for fifo_rd_ctrl_prog.
// Directed scenarios then random traffic against a counter-based model.
module tb_fifo_rd_ctrl_prog;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int PTR_W  = 5;
    localparam int PMASK  = 2 * DEPTH - 1;
    localparam int AMASK  = DEPTH - 1;

    logic              RCLK;
    logic              RRSTn;
    logic              RINC;
    logic [PTR_W-1:0]  RQ2_WPTR;
    logic              RAE_WE;
    logic [PTR_W-1:0]  RAE_THRESH;
    logic              RUF_CLR;
    logic [PTR_W-1:0]  RPTR;
    logic [ADDR_W-1:0] RADDR;
    logic              REMPTY;
    logic              RALMOST_EMPTY;
    logic [PTR_W-1:0]  RLEVEL;
    logic              RUNDERFLOW;

    fifo_rd_ctrl_prog #(
        .DEPTH (DEPTH),
        .AE_RST(2)
    ) dut (
        .RCLK         (RCLK),
        .RRSTn        (RRSTn),
        .RINC         (RINC),
        .RQ2_WPTR     (RQ2_WPTR),
        .RAE_WE       (RAE_WE),
        .RAE_THRESH   (RAE_THRESH),
        .RUF_CLR      (RUF_CLR),
        .RPTR         (RPTR),
        .RADDR        (RADDR),
        .REMPTY       (REMPTY),
        .RALMOST_EMPTY(RALMOST_EMPTY),
        .RLEVEL       (RLEVEL),
        .RUNDERFLOW   (RUNDERFLOW)
    );

    initial RCLK = 1'b0;
    always #5 RCLK = ~RCLK;

    typedef struct {
        bit rst;
        bit pop;
        int rptr;
        int raddr;
        int empty;
        int ae;
        int level;
        int uf;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    bit running = 0;

    // Reference model: plain read/write word counts.
    int m_rd = 0;
    int m_wr = 0;
    int m_thr = 2;
    bit m_empty = 1;
    bit m_uf = 0;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the expected post-edge state goes to the scoreboard.
    task automatic step(input bit rst_n, input bit rinc, input int wr,
                        input bit we, input int thr, input bit clr);
        exp_t e;
        int lvl;
        @(negedge RCLK);
        running    = 1;
        RRSTn      = rst_n;
        RINC       = rinc;
        RQ2_WPTR   = PTR_W'(gray(wr & PMASK));
        RAE_WE     = we;
        RAE_THRESH = PTR_W'(thr);
        RUF_CLR    = clr;
        e.rst = !rst_n;
        e.pop = 0;
        if (!rst_n) begin
            m_rd    = 0;
            m_wr    = 0;
            m_thr   = 2;
            m_empty = 1;
            m_uf    = 0;
            e.ae    = 1;
            lvl     = 0;
        end else begin
            m_wr = wr;
            if (rinc && m_empty) begin
                m_uf = 1;
            end else if (clr) begin
                m_uf = 0;
            end
            if (rinc && !m_empty) begin
                m_rd++;
                e.pop = 1;
            end
            lvl     = m_wr - m_rd;
            m_empty = (lvl == 0);
            e.ae    = (lvl <= m_thr);
            if (we) m_thr = thr;
        end
        e.rptr  = gray(m_rd & PMASK);
        e.raddr = m_rd & AMASK;
        e.empty = m_empty;
        e.level = lvl;
        e.uf    = m_uf;
        sb.push_back(e);
    endtask

    // Monitor: after every edge, pop one expectation and compare.
    initial begin : monitor
        exp_t e;
        int prev;
        prev = 0;
        forever begin
            @(posedge RCLK);
            #1;
            if (sb.size() == 0) begin
                if (running) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underrun: got 0 entries expected 1");
                end
            end else begin
                e = sb.pop_front();
                chk("rptr", int'(RPTR), e.rptr);
                chk("raddr", int'(RADDR), e.raddr);
                chk("rempty", int'(REMPTY), e.empty);
                chk("ralmost_empty", int'(RALMOST_EMPTY), e.ae);
                chk("rlevel", int'(RLEVEL), e.level);
                chk("runderflow", int'(RUNDERFLOW), e.uf);
                if (e.pop && !e.rst) begin
                    chk("rptr_hamming", $countones(int'(RPTR) ^ prev), 1);
                end
            end
            prev = int'(RPTR);
        end
    end

    initial begin : stim
        int wr;
        RRSTn      = 1'b0;
        RINC       = 1'b0;
        RQ2_WPTR   = '0;
        RAE_WE     = 1'b0;
        RAE_THRESH = '0;
        RUF_CLR    = 1'b0;

        // Reset held three cycles.
        repeat (3) step(0, 0, 0, 0, 0, 0);
        // Fill to five words.
        step(1, 0, 5, 0, 0, 0);
        // Drain all five.
        repeat (5) step(1, 1, 5, 0, 0, 0);
        // Underflow set, set-over-clear, clear.
        step(1, 1, 5, 0, 0, 0);
        step(1, 1, 5, 0, 0, 1);
        step(1, 0, 5, 0, 0, 1);
        step(1, 0, 5, 0, 0, 0);
        // Wrap: 40 pops with the writer kept four words ahead.
        step(1, 0, m_rd + 4, 0, 0, 0);
        repeat (40) step(1, 1, m_rd + 4, 0, 0, 0);
        // Threshold load at level 6, then reset mid-operation.
        step(1, 0, m_rd + 6, 0, 0, 0);
        step(1, 0, m_wr, 1, 8, 0);
        step(1, 0, m_wr, 0, 0, 0);
        step(1, 0, m_wr, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // Threshold edge cases: 0 tracks empty, >= DEPTH always set.
        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 16, 1, 16, 0);
        step(1, 0, 16, 0, 0, 0);
        step(1, 0, 16, 1, 31, 0);
        step(1, 1, 16, 0, 0, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bit rst_n;
            bit rinc;
            bit we;
            bit clr;
            int thr;
            rst_n = ($urandom_range(0, 299) != 0);
            rinc  = ($urandom_range(0, 1) == 1);
            we    = ($urandom_range(0, 19) == 0);
            clr   = ($urandom_range(0, 9) == 0);
            thr   = (($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                                 : $urandom_range(0, DEPTH));
            wr = m_wr;
            if ((wr - m_rd) < DEPTH && $urandom_range(0, 9) < 4) wr++;
            if (!rst_n) wr = 0;
            step(rst_n, rinc, wr, we, thr, clr);
        end

        @(negedge RCLK);
        running = 0;
        RINC    = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
